// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - challenge engine FSM states
//   DEF_SEL_W - default oscillator-select width
//   COUNT_W   - width of the oscillator counters feeding the comparator
//   timer_w() - bit width needed to hold the longest window/settle length
package puf_pkg;

    localparam int DEF_SEL_W = 5;
    localparam int COUNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // ceil(log2(max(a, b) + 1))
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter that flags the final cycle of a timed interval.
// Latency: done is asserted combinationally in the last enabled cycle of the interval.
// Backpressure: none; the counter only moves while en is high.
//
// Ports:
//   clk      - system clock
//   rst_n    - synchronous reset, active high (1 = reset)
//   load     - reload the counter with load_val (wins over counting)
//   load_val - interval length minus one
//   en       - count this cycle
//   done     - en is high and the counter has reached zero
module puf_window_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loading length-1 means an interval of L enabled cycles ends
    // on the cycle where the counter reads zero.
    assign done = en && (cnt == '0);

endmodule

// File: rtl/puf_challenge_engine.sv
// Issues oscillator-pair challenges, times clear/run/settle windows and builds the response word.
// Latency: N_BITS*(WIN_CYCLES+SETTLE_CYCLES+2)+1 cycles from start accept to resp_valid.
// Backpressure: holds resp/resp_valid in DONE until resp_ready; start is ignored while busy.
//
// Ports:
//   clk, rst_n         - system clock, synchronous active-high reset (1 = reset)
//   start, seed        - request a response; seed is the base challenge, taken on accept
//   osc_ena, osc_clr   - oscillator enable (RUN only) and counter clear (CLEAR only)
//   sel_a, sel_b       - oscillator pair selects: seed+2k and seed+2k+1, wrapping
//   count_a, count_b   - frozen counter values, compared in SAMPLE
//   resp, resp_valid   - response word and its valid flag
//   resp_ready         - consumer accepts the response
//   busy               - high in every state except IDLE
module puf_challenge_engine
    import puf_pkg::*;
#(
    parameter int WIN_CYCLES    = 256,
    parameter int SETTLE_CYCLES = 4,
    parameter int N_BITS        = 8,
    parameter int SEL_W         = DEF_SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SEL_W-1:0]   seed,
    output logic               osc_ena,
    output logic               osc_clr,
    output logic [SEL_W-1:0]   sel_a,
    output logic [SEL_W-1:0]   sel_b,
    input  logic [COUNT_W-1:0] count_a,
    input  logic [COUNT_W-1:0] count_b,
    output logic [N_BITS-1:0]  resp,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               busy
);

    localparam int TW = timer_w(WIN_CYCLES, SETTLE_CYCLES);
    localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [TW-1:0] RUN_LOAD    = TW'(WIN_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST      = KW'(N_BITS - 1);

    state_t        state;
    logic [KW-1:0] k;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_done;

    // One timer serves both intervals: it is reloaded for RUN while in
    // CLEAR, and for SETTLE on the last RUN cycle, so each interval starts
    // from a fresh count on state entry.
    always_comb begin
        tmr_en   = (state == RUN) || (state == SETTLE);
        tmr_load = (state == CLEAR) || ((state == RUN) && tmr_done);
        tmr_val  = (state == CLEAR) ? RUN_LOAD : SETTLE_LOAD;
    end

    puf_window_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // All outputs are registered and updated on the transition into the
    // state that owns them, so they line up with the state register.
    // sel_a/sel_b double as the latched seed: they are loaded with seed and
    // seed+1 on accept and advance by two per bit, wrapping modulo 2^SEL_W.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            k          <= '0;
            resp       <= '0;
            resp_valid <= 1'b0;
            osc_ena    <= 1'b0;
            osc_clr    <= 1'b0;
            sel_a      <= '0;
            sel_b      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        k       <= '0;
                        resp    <= '0;
                        sel_a   <= seed;
                        sel_b   <= seed + SEL_W'(1);
                        osc_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                CLEAR: begin
                    state   <= RUN;
                    osc_clr <= 1'b0;
                    osc_ena <= 1'b1;
                end

                RUN: begin
                    if (tmr_done) begin
                        state   <= SETTLE;
                        osc_ena <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (tmr_done) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    // Raw unsigned compare of the frozen counts; a tie reads as 0.
                    resp[k] <= (count_a > count_b);
                    if (k == K_LAST) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                    end else begin
                        state   <= CLEAR;
                        k       <= k + 1'b1;
                        sel_a   <= sel_a + SEL_W'(2);
                        sel_b   <= sel_b + SEL_W'(2);
                        osc_clr <= 1'b1;
                    end
                end

                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_engine.sv
`timescale 1ns/1ps
module tb_puf_challenge_engine;
    import puf_pkg::*;

    localparam int WIN = 4;
    localparam int SET = 2;
    localparam int NB  = 4;
    localparam int SW  = 5;
    localparam int P   = WIN + SET + 2;

    localparam int M_ALT = 0;   // even k: 10>3, odd k: 2<9   -> 0101
    localparam int M_TIE = 1;   // 7 vs 7 always              -> 0000
    localparam int M_UNS = 2;   // 0x80 vs 0x7F (unsigned)    -> 1111
    localparam int M_INV = 3;   // even k: 3<10, odd k: 9>2   -> 1010

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [SW-1:0] seed;
    logic          osc_ena;
    logic          osc_clr;
    logic [SW-1:0] sel_a;
    logic [SW-1:0] sel_b;
    logic [7:0]    count_a;
    logic [7:0]    count_b;
    logic [NB-1:0] resp;
    logic          resp_valid;
    logic          resp_ready;
    logic          busy;

    puf_challenge_engine #(
        .WIN_CYCLES    (WIN),
        .SETTLE_CYCLES (SET),
        .N_BITS        (NB),
        .SEL_W         (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .osc_ena    (osc_ena),
        .osc_clr    (osc_clr),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .count_a    (count_a),
        .count_b    (count_b),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void good_counts(input int m, input int kk,
                                        output logic [7:0] a, output logic [7:0] b);
        case (m)
            M_ALT:   if (kk % 2 == 0) begin a = 8'd10; b = 8'd3;  end
                     else             begin a = 8'd2;  b = 8'd9;  end
            M_TIE:   begin a = 8'd7;   b = 8'd7;   end
            M_UNS:   begin a = 8'h80;  b = 8'h7f;  end
            default: if (kk % 2 == 0) begin a = 8'd3;  b = 8'd10; end
                     else             begin a = 8'd9;  b = 8'd2;  end
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Oscillator/counter model + protocol monitor, acting 2ns after each
    // rising edge. Counts are only truthful in the cycle that follows
    // SET disabled cycles after a run window; any other time they carry
    // values that would flip the response bit.
    // ------------------------------------------------------------------
    int mode     = M_ALT;
    int seed_cur = 0;
    int kk       = 0;
    int off_cnt  = 0;
    int ena_len  = 0;
    int clr_len  = 0;
    int last_ena_len = 0;
    int last_clr_len = 0;
    int n_samp   = 0;
    bit overlap  = 1'b0;
    bit prev_busy = 1'b0;
    bit prev_ena  = 1'b0;
    bit prev_clr  = 1'b0;

    initial begin
        logic [7:0] ga, gb;
        bit samp;
        count_a = 8'd0;
        count_b = 8'd0;
        forever begin
            @(posedge clk);
            #2;
            if (osc_ena && osc_clr) overlap = 1'b1;
            if (osc_ena) ena_len++;
            else begin
                if (prev_ena) last_ena_len = ena_len;
                ena_len = 0;
            end
            if (osc_clr) clr_len++;
            else begin
                if (prev_clr) last_clr_len = clr_len;
                clr_len = 0;
            end
            if (osc_clr) kk = prev_busy ? kk + 1 : 0;
            if (osc_ena || osc_clr) off_cnt = 0;
            else if (off_cnt < 1000) off_cnt++;

            samp = busy && !resp_valid && (off_cnt == SET + 1);
            if (samp) begin
                n_samp++;
                check("clr_pulse_len", last_clr_len, 1);
                check("ena_window_len", last_ena_len, WIN);
                check("ena_clr_overlap", int'(overlap), 0);
                check($sformatf("sel_a_bit%0d", kk), int'(sel_a), (seed_cur + 2 * kk) % 32);
                check($sformatf("sel_b_bit%0d", kk), int'(sel_b), (seed_cur + 2 * kk + 1) % 32);
            end

            good_counts(mode, kk, ga, gb);
            if (samp) begin
                count_a = ga;
                count_b = gb;
            end else if (ga == gb) begin
                count_a = 8'd200;
                count_b = 8'd1;
            end else begin
                count_a = gb;
                count_b = ga;
            end

            prev_busy = busy;
            prev_ena  = osc_ena;
            prev_clr  = osc_clr;
        end
    end

    // ------------------------------------------------------------------
    // Driver / checker, acting 1ns after each rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [SW-1:0] s, input int m,
                           output logic [NB-1:0] r, output int lat);
        mode     = m;
        seed_cur = int'(s);
        seed     = s;
        n_samp   = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("clr_after_start", int'(osc_clr), 1);
        check("ena_after_start", int'(osc_ena), 0);
        check("resp_cleared_on_start", int'(resp), 0);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            tick();
            lat++;
        end
        r = resp;
    endtask

    task automatic accept(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(resp_valid), 0);
        check({tag, "_busy_drop"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [SW-1:0] seed;
        int            mode;
        logic [NB-1:0] exp_resp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [NB-1:0] r;
        logic [NB-1:0] r0;
        int  lat;
        int  w;
        bit  ok;

        vecs[0] = '{seed: 5'd5,  mode: M_ALT, exp_resp: 4'b0101};
        vecs[1] = '{seed: 5'd30, mode: M_ALT, exp_resp: 4'b0101};
        vecs[2] = '{seed: 5'd0,  mode: M_TIE, exp_resp: 4'b0000};
        vecs[3] = '{seed: 5'd31, mode: M_UNS, exp_resp: 4'b1111};
        vecs[4] = '{seed: 5'd12, mode: M_INV, exp_resp: 4'b1010};

        rst_n      = 1'b1;
        start      = 1'b0;
        seed       = '0;
        resp_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();

        // Reset state
        check("rst_resp", int'(resp), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_osc_ena", int'(osc_ena), 0);
        check("rst_osc_clr", int'(osc_clr), 0);
        check("rst_sel_a", int'(sel_a), 0);
        check("rst_sel_b", int'(sel_b), 0);
        check("rst_busy", int'(busy), 0);

        // Table-driven requests
        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i].seed, vecs[i].mode, r, lat);
            check($sformatf("v%0d_latency", i), lat, NB * P + 1);
            check($sformatf("v%0d_resp", i), int'(r), int'(vecs[i].exp_resp));
            check($sformatf("v%0d_bits_sampled", i), n_samp, NB);
            accept($sformatf("v%0d", i));
            check($sformatf("v%0d_resp_hold_idle", i), int'(resp), int'(vecs[i].exp_resp));
        end

        // Backpressure, ignored start pulses and seed changes while busy
        mode     = M_INV;
        seed_cur = 9;
        seed     = 5'd9;
        n_samp   = 0;
        start    = 1'b1;
        tick();
        seed  = 5'd3;
        start = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            start = (lat % 3 == 0);
            tick();
            lat++;
        end
        check("bp_latency", lat, NB * P + 1);
        r0 = resp;
        check("bp_resp", int'(r0), 4'b1010);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            start = (c % 2 == 0);
            tick();
            if (resp != r0 || !busy || !resp_valid) ok = 1'b0;
        end
        check("bp_hold_stable", int'(ok), 1);
        start = 1'b0;
        accept("bp");
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy || resp_valid || osc_clr || osc_ena) ok = 1'b0;
        end
        check("bp_no_extra_response", int'(ok), 1);
        check("bp_resp_kept", int'(resp), 4'b1010);

        // Reset in the middle of bit 2's run window
        mode     = M_ALT;
        seed_cur = 5;
        seed     = 5'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!(kk == 2 && osc_ena) && w < 200) begin
            tick();
            w++;
        end
        check("reach_bit2_run", int'(w < 200), 1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("midrst_state", int'(dut.state), int'(IDLE));
        check("midrst_resp", int'(resp), 0);
        check("midrst_resp_valid", int'(resp_valid), 0);
        check("midrst_osc_ena", int'(osc_ena), 0);
        check("midrst_osc_clr", int'(osc_clr), 0);
        check("midrst_sel_a", int'(sel_a), 0);
        check("midrst_sel_b", int'(sel_b), 0);
        check("midrst_busy", int'(busy), 0);

        run_req(5'd0, M_ALT, r, lat);
        check("post_rst_latency", lat, NB * P + 1);
        check("post_rst_resp", int'(r), 4'b0101);
        check("post_rst_bits_sampled", n_samp, NB);
        accept("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
